// File: rtl/four_bit_unsigned_divider_if.sv
// four_bit_unsigned_divider_if: start/done handshake and operand/result bus for the divider.
interface four_bit_unsigned_divider_if;
    logic       start;
    logic [7:0] dividend;
    logic [3:0] divisor;
    logic       busy;
    logic       done;
    logic [7:0] quotient;
    logic [3:0] remainder;
    logic       div_by_zero;
    modport master (output start, dividend, divisor,
                    input  busy, done, quotient, remainder, div_by_zero);
    modport slave  (input  start, dividend, divisor,
                    output busy, done, quotient, remainder, div_by_zero);
endinterface

// File: rtl/four_bit_unsigned_divider.sv
// four_bit_unsigned_divider: 8-bit by 4-bit restoring divider, one quotient bit per clock.
module four_bit_unsigned_divider (
    input logic clk,
    input logic rst,
    four_bit_unsigned_divider_if.slave bus
);
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
    state_t     state;
    logic [7:0] dvd;
    logic [3:0] dvs;
    logic [3:0] part;
    logic [7:0] q;
    logic [2:0] cnt;
    logic [4:0] sh;
    logic [4:0] nxt;
    logic       ge;
    // part always ends below the divisor, so the 5-bit shifted value never overflows
    always_comb begin
        sh  = {part, dvd[7]};
        ge  = sh >= {1'b0, dvs};
        nxt = ge ? sh - {1'b0, dvs} : sh;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= IDLE;
            dvd             <= '0;
            dvs             <= '0;
            part            <= '0;
            q               <= '0;
            cnt             <= '0;
            bus.busy        <= 1'b0;
            bus.done        <= 1'b0;
            bus.quotient    <= '0;
            bus.remainder   <= '0;
            bus.div_by_zero <= 1'b0;
        end else begin
            case (state)
                IDLE: if (bus.start) begin
                    dvd      <= bus.dividend;
                    dvs      <= bus.divisor;
                    part     <= '0;
                    q        <= '0;
                    cnt      <= '0;
                    bus.busy <= 1'b1;
                    state    <= (bus.divisor != 4'd0) ? CALC : DONE;
                end
                CALC: begin
                    dvd  <= {dvd[6:0], 1'b0};
                    part <= nxt[3:0];
                    q    <= {q[6:0], ge};
                    cnt  <= cnt + 3'd1;
                    if (cnt == 3'd7) begin
                        bus.quotient    <= {q[6:0], ge};
                        bus.remainder   <= nxt[3:0];
                        bus.div_by_zero <= 1'b0;
                        bus.done        <= 1'b1;
                        state           <= DONE;
                    end
                end
                DONE: begin
                    // entering from IDLE means a zero divisor: publish it one cycle later
                    if (!bus.done) begin
                        bus.quotient    <= 8'hFF;
                        bus.remainder   <= 4'h0;
                        bus.div_by_zero <= 1'b1;
                        bus.done        <= 1'b1;
                    end else begin
                        bus.done <= 1'b0;
                        bus.busy <= 1'b0;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_four_bit_unsigned_divider.sv
// tb_four_bit_unsigned_divider: vector table, handshake corner cases, exhaustive sweep and random ops.
module tb_four_bit_unsigned_divider;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    four_bit_unsigned_divider_if bus ();
    four_bit_unsigned_divider dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct {
        logic [7:0] a;
        logic [3:0] b;
        logic [7:0] q;
        logic [3:0] r;
        logic       dz;
        int         lat;
    } vec_t;

    int total = 0;
    int bad = 0;
    logic [7:0] pq = '0;
    logic [3:0] pr = '0;
    logic       pdz = 1'b0;
    vec_t       vecs[6];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    function automatic logic [7:0] mul4(input logic [3:0] x, input logic [3:0] y);
        logic [7:0] p = '0;
        for (int i = 0; i < 4; i++) if (y[i]) p = p + ({4'b0, x} << i);
        return p;
    endfunction

    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while (bus.busy && n < 50) begin
            @(negedge clk);
            n++;
        end
    endtask

    // accept edge E0, then count edges until done; operands are scrambled after E0
    task automatic run_op(input logic [7:0] a, input logic [3:0] b, output int lat);
        wait_idle();
        bus.start = 1'b1;
        bus.dividend = a;
        bus.divisor = b;
        @(posedge clk);
        #1 bus.start = 1'b0;
        lat = 0;
        while (lat < 20) begin
            bus.dividend = 8'($urandom);
            bus.divisor = 4'($urandom);
            @(posedge clk);
            #1 lat++;
            if (bus.done) break;
            if (lat == 3) chk("hold", {bus.quotient, bus.remainder, bus.div_by_zero}, {pq, pr, pdz});
        end
        if (!bus.done) lat = 99;
    endtask

    task automatic check_result(input vec_t v, input int lat);
        chk("lat", lat, v.lat);
        chk("quot", bus.quotient, v.q);
        chk("rem", bus.remainder, v.r);
        chk("dz", bus.div_by_zero, v.dz);
        if (v.b != 4'd0) chk("rem<div", bus.remainder < v.b, 1);
        if (bus.quotient < 8'd16) chk("mul", mul4(bus.quotient[3:0], v.b) + bus.remainder, v.a);
        pq = v.q;
        pr = v.r;
        pdz = v.dz;
    endtask

    function automatic vec_t model(input logic [7:0] a, input logic [3:0] b);
        vec_t v;
        v.a = a;
        v.b = b;
        v.dz = (b == 4'd0);
        v.q = v.dz ? 8'hFF : 8'(a / b);
        v.r = v.dz ? 4'h0 : 4'(a % b);
        v.lat = v.dz ? 1 : 8;
        return v;
    endfunction

    task automatic do_vec(input vec_t v);
        int lat;
        run_op(v.a, v.b, lat);
        check_result(v, lat);
    endtask

    initial begin
        int dones, busy_bad, lat;
        logic [7:0] cq;
        logic [3:0] cr;
        vecs[0] = '{8'd200, 4'd7, 8'd28, 4'd4, 1'b0, 8};
        vecs[1] = '{8'd255, 4'd1, 8'd255, 4'd0, 1'b0, 8};
        vecs[2] = '{8'd13, 4'd15, 8'd0, 4'd13, 1'b0, 8};
        vecs[3] = '{8'd0, 4'd9, 8'd0, 4'd0, 1'b0, 8};
        vecs[4] = '{8'd100, 4'd0, 8'hFF, 4'd0, 1'b1, 1};
        vecs[5] = '{8'd100, 4'd10, 8'd10, 4'd0, 1'b0, 8};
        bus.start = 1'b0;
        bus.dividend = '0;
        bus.divisor = '0;
        repeat (3) @(posedge clk);
        #1 chk("reset", {bus.busy, bus.done, bus.quotient, bus.remainder, bus.div_by_zero}, '0);
        rst = 1'b0;
        for (int i = 0; i < 6; i++) do_vec(vecs[i]);

        // start while busy is ignored
        wait_idle();
        bus.start = 1'b1;
        bus.dividend = 8'd200;
        bus.divisor = 4'd7;
        @(posedge clk);
        #1 bus.start = 1'b0;
        dones = 0;
        busy_bad = 0;
        cq = '0;
        cr = '0;
        for (int i = 1; i <= 12; i++) begin
            bus.start = (i == 3);
            bus.dividend = 8'd50;
            bus.divisor = 4'd3;
            @(posedge clk);
            #1;
            if (bus.done) begin
                dones++;
                cq = bus.quotient;
                cr = bus.remainder;
            end
            if (i <= 8 && !bus.busy) busy_bad++;
        end
        bus.start = 1'b0;
        chk("busy_dones", dones, 1);
        chk("busy_quot", cq, 28);
        chk("busy_rem", cr, 4);
        chk("busy_high", busy_bad, 0);
        pq = 8'd28;
        pr = 4'd4;
        pdz = 1'b0;

        // reset mid-operation
        wait_idle();
        bus.start = 1'b1;
        bus.dividend = 8'd200;
        bus.divisor = 4'd7;
        @(posedge clk);
        #1 bus.start = 1'b0;
        repeat (4) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 chk("mid_rst", {bus.busy, bus.done, bus.quotient, bus.remainder, bus.div_by_zero}, '0);
        rst = 1'b0;
        dones = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            #1 if (bus.done) dones++;
        end
        chk("rst_nodone", dones, 0);
        pq = '0;
        pr = '0;
        pdz = 1'b0;
        do_vec('{8'd90, 4'd9, 8'd10, 4'd0, 1'b0, 8});

        for (int b = 0; b < 16; b++)
            for (int a = 0; a < 256; a++) do_vec(model(8'(a), 4'(b)));

        for (int i = 0; i < 200; i++) begin
            vec_t v = model(8'($urandom), 4'($urandom_range(0, 15)));
            run_op(v.a, v.b, lat);
            check_result(v, lat);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
